// File: rtl/network_requester_interface.sv
// network_requester_interface: turns single-outstanding core loads/stores into router packets and returns load data or timeout errors
// Core side   : reqValid/reqReady/reqWrite/reqAddress/reqData in, rspValid/rspData/rspError out
// Router out  : destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut (one-cycle packets)
// Router in   : destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn
// Status      : droppedCount counts incoming packets not consumed as the awaited response (saturates at 255)
module network_requester_interface #(
   parameter int NET_ADDR_W     = 4,
   parameter int BANK_ADDR_W    = 8,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_RETRIES    = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NET_ADDR_W-1:0]         localAddress,
   input  logic                          reqValid,
   output logic                          reqReady,
   input  logic                          reqWrite,
   input  logic [NET_ADDR_W+BANK_ADDR_W-1:0] reqAddress,
   input  logic [DATA_W-1:0]             reqData,
   output logic                          rspValid,
   output logic [DATA_W-1:0]             rspData,
   output logic                          rspError,
   output logic [7:0]                    droppedCount,
   output logic [NET_ADDR_W+BANK_ADDR_W-1:0] destinationAddressOut,
   output logic [NET_ADDR_W-1:0]         requesterAddressOut,
   output logic                          readOut,
   output logic                          writeOut,
   output logic [DATA_W-1:0]             dataOut,
   input  logic [NET_ADDR_W+BANK_ADDR_W-1:0] destinationAddressIn,
   input  logic [NET_ADDR_W-1:0]         requesterAddressIn,
   input  logic                          readIn,
   input  logic                          writeIn,
   input  logic [DATA_W-1:0]             dataIn
);
   localparam int AW = NET_ADDR_W + BANK_ADDR_W;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
   typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;
   state_t state, nxt;
   logic live;
   logic wr;
   logic [AW-1:0] addr;
   logic [DATA_W-1:0] data;
   logic [TW-1:0] timer;
   logic [RW-1:0] retries;
   logic send, hit, expire, retry;
   // live keeps reqReady low while reset is held, even though the state register already reads IDLE
   assign reqReady = live && state == IDLE;
   assign rspValid = state == RESP;
   assign send = state == SEND;
   assign destinationAddressOut = send ? addr : '0;
   assign requesterAddressOut = send ? localAddress : '0;
   assign writeOut = send && wr;
   assign readOut = send && !wr;
   assign dataOut = send && wr ? data : '0;
   assign hit = state == WAIT && writeIn && destinationAddressIn[AW-1 -: NET_ADDR_W] == localAddress
                && requesterAddressIn == addr[AW-1 -: NET_ADDR_W];
   // a response arriving in the expiry cycle still wins
   assign expire = state == WAIT && !hit && timer == TW'(TIMEOUT_CYCLES - 1);
   assign retry = retries < RW'(MAX_RETRIES);
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE: nxt = reqValid && reqReady ? SEND : IDLE;
         SEND: nxt = wr ? RESP : WAIT;
         WAIT: nxt = hit ? RESP : expire ? (retry ? SEND : RESP) : WAIT;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         live <= 1'b0;
         wr <= 1'b0;
         addr <= '0;
         data <= '0;
         timer <= '0;
         retries <= '0;
         rspData <= '0;
         rspError <= 1'b0;
         droppedCount <= '0;
      end else begin
         live <= 1'b1;
         if (state == IDLE && reqValid && reqReady) begin
            wr <= reqWrite;
            addr <= reqAddress;
            data <= reqData;
            retries <= '0;
         end
         if (send) timer <= '0;
         if (state == WAIT && !hit && !expire) timer <= timer + 1'b1;
         if (expire && retry) retries <= retries + 1'b1;
         if (hit) begin
            rspData <= dataIn;
            rspError <= 1'b0;
         end
         if (expire && !retry) begin
            rspData <= '0;
            rspError <= 1'b1;
         end
         if (send && wr) begin
            rspData <= '0;
            rspError <= 1'b0;
         end
         if ((readIn || writeIn) && !hit && droppedCount != 8'hFF) droppedCount <= droppedCount + 1'b1;
      end
endmodule

// File: tb/tb_network_requester_interface.sv
// tb_network_requester_interface: directed self-checking bench for network_requester_interface
module tb_network_requester_interface;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [3:0] localAddress = 4'd4;
   logic reqValid = 1'b0, reqWrite = 1'b0;
   logic [11:0] reqAddress = '0;
   logic [31:0] reqData = '0;
   logic reqReady, rspValid, rspError;
   logic [31:0] rspData;
   logic [7:0] droppedCount;
   logic [11:0] destinationAddressOut;
   logic [3:0] requesterAddressOut;
   logic readOut, writeOut;
   logic [31:0] dataOut;
   logic [11:0] destinationAddressIn = '0;
   logic [3:0] requesterAddressIn = '0;
   logic readIn = 1'b0, writeIn = 1'b0;
   logic [31:0] dataIn = '0;
   int vecs = 0, errs = 0;

   network_requester_interface dut (
      .clk(clk), .reset(reset), .localAddress(localAddress),
      .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
      .reqAddress(reqAddress), .reqData(reqData),
      .rspValid(rspValid), .rspData(rspData), .rspError(rspError),
      .droppedCount(droppedCount),
      .destinationAddressOut(destinationAddressOut), .requesterAddressOut(requesterAddressOut),
      .readOut(readOut), .writeOut(writeOut), .dataOut(dataOut),
      .destinationAddressIn(destinationAddressIn), .requesterAddressIn(requesterAddressIn),
      .readIn(readIn), .writeIn(writeIn), .dataIn(dataIn)
   );

   always #5 clk = ~clk;

   task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      reqValid = 1'b1; reqWrite = w; reqAddress = a; reqData = d;
      @(negedge clk);
      reqValid = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      @(negedge clk);
      vecs++;
      if ({reqReady, rspValid, rspData, rspError, droppedCount, destinationAddressOut, requesterAddressOut,
           readOut, writeOut, dataOut} !== '0) begin
         errs++; $display("FAIL reset_outputs: outputs not all zero during reset, reqReady=%b rspValid=%b", reqReady, rspValid);
      end
      reset = 1'b1;
      @(negedge clk);
      vecs++;
      if (reqReady !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", reqReady); end
   endtask

   task automatic test_store;
      issue(1'b1, 12'h210, 32'h2);
      vecs++;
      if ({writeOut, readOut, destinationAddressOut, requesterAddressOut, dataOut, reqReady, rspValid}
          !== {1'b1, 1'b0, 12'h210, 4'd4, 32'h2, 1'b0, 1'b0}) begin
         errs++; $display("FAIL store_packet: wr=%b rd=%b dst=%h src=%h data=%h want 1 0 210 4 00000002",
                          writeOut, readOut, destinationAddressOut, requesterAddressOut, dataOut);
      end
      @(negedge clk);
      vecs++;
      if ({writeOut, rspValid, rspError, rspData} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
         errs++; $display("FAIL store_rsp: wr=%b rspValid=%b err=%b data=%h want 0 1 0 0", writeOut, rspValid, rspError, rspData);
      end
      @(negedge clk);
      vecs++;
      if ({rspValid, reqReady} !== 2'b01) begin errs++; $display("FAIL store_done: rspValid=%b reqReady=%b want 0 1", rspValid, reqReady); end
   endtask

   task automatic test_load;
      issue(1'b0, 12'h805, 32'hFFFF_FFFF);
      vecs++;
      if ({readOut, writeOut, destinationAddressOut, requesterAddressOut, dataOut} !== {1'b1, 1'b0, 12'h805, 4'd4, 32'h0}) begin
         errs++; $display("FAIL load_packet: rd=%b wr=%b dst=%h src=%h data=%h want 1 0 805 4 0",
                          readOut, writeOut, destinationAddressOut, requesterAddressOut, dataOut);
      end
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      vecs++;
      if ({rspValid, readOut} !== 2'b00) begin errs++; $display("FAIL load_wait: rspValid=%b readOut=%b want 0 0", rspValid, readOut); end
      writeIn = 1'b1; destinationAddressIn = 12'h400; requesterAddressIn = 4'd8; dataIn = 32'hCAFE;
      @(negedge clk);
      writeIn = 1'b0;
      vecs++;
      if ({rspValid, rspError, rspData, droppedCount} !== {1'b1, 1'b0, 32'hCAFE, 8'd0}) begin
         errs++; $display("FAIL load_rsp: v=%b err=%b data=%h dropped=%0d want 1 0 0000cafe 0", rspValid, rspError, rspData, droppedCount);
      end
   endtask

   task automatic test_timeout;
      issue(1'b0, 12'h6AA, 32'h0);
      vecs++;
      if (readOut !== 1'b1) begin errs++; $display("FAIL timeout_first_send: readOut=%b want 1", readOut); end
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            vecs++;
            if ({readOut, rspValid, rspData} !== {1'b0, 1'b0, 32'hCAFE}) begin
               errs++; $display("FAIL timeout_wait[%0d][%0d]: rd=%b v=%b data=%h want 0 0 0000cafe", p, i, readOut, rspValid, rspData);
            end
         end
         @(negedge clk);
         if (p == 0) begin
            vecs++;
            if ({readOut, destinationAddressOut} !== {1'b1, 12'h6AA}) begin
               errs++; $display("FAIL timeout_resend: rd=%b dst=%h want 1 6aa", readOut, destinationAddressOut);
            end
         end else begin
            vecs++;
            if ({rspValid, rspError, rspData, readOut} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
               errs++; $display("FAIL timeout_error: v=%b err=%b data=%h rd=%b want 1 1 0 0", rspValid, rspError, rspData, readOut);
            end
         end
      end
      @(negedge clk);
      vecs++;
      if ({rspValid, rspError, reqReady} !== 3'b011) begin
         errs++; $display("FAIL timeout_hold: v=%b err=%b ready=%b want 0 1 1", rspValid, rspError, reqReady);
      end
   endtask

   task automatic test_mismatch;
      issue(1'b0, 12'h6BB, 32'h0);
      @(negedge clk);
      writeIn = 1'b1; destinationAddressIn = 12'h400; requesterAddressIn = 4'd3; dataIn = 32'hBAD;
      @(negedge clk);
      writeIn = 1'b0; readIn = 1'b1; requesterAddressIn = 4'd6;
      @(negedge clk);
      readIn = 1'b0;
      vecs++;
      if ({rspValid, droppedCount} !== {1'b0, 8'd2}) begin
         errs++; $display("FAIL mismatch_drop: v=%b dropped=%0d want 0 2", rspValid, droppedCount);
      end
      writeIn = 1'b1; destinationAddressIn = 12'h4BB; requesterAddressIn = 4'd6; dataIn = 32'h1234;
      @(negedge clk);
      writeIn = 1'b0;
      vecs++;
      if ({rspValid, rspError, rspData, droppedCount} !== {1'b1, 1'b0, 32'h1234, 8'd2}) begin
         errs++; $display("FAIL mismatch_rsp: v=%b err=%b data=%h dropped=%0d want 1 0 00001234 2", rspValid, rspError, rspData, droppedCount);
      end
      @(negedge clk);
   endtask

   task automatic test_saturate;
      logic [7:0] want;
      for (int i = 0; i < 300; i++) begin
         writeIn = 1'b1; destinationAddressIn = 12'h400; requesterAddressIn = 4'd6; dataIn = $urandom;
         want = (2 + i > 255) ? 8'd255 : 8'(2 + i);
         vecs++;
         if ({reqReady, droppedCount} !== {1'b1, want}) begin
            errs++; $display("FAIL saturate[%0d]: ready=%b dropped=%0d want 1 %0d", i, reqReady, droppedCount, want);
         end
         @(negedge clk);
      end
      writeIn = 1'b0;
      @(negedge clk);
      vecs++;
      if ({droppedCount, rspValid, rspData} !== {8'd255, 1'b0, 32'h1234}) begin
         errs++; $display("FAIL saturate_final: dropped=%0d v=%b data=%h want 255 0 00001234", droppedCount, rspValid, rspData);
      end
   endtask

   task automatic test_abort;
      issue(1'b0, 12'h7CC, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      vecs++;
      if ({reqReady, rspValid, droppedCount, rspData, rspError} !== '0) begin
         errs++; $display("FAIL abort_reset: ready=%b v=%b dropped=%0d data=%h err=%b want all 0", reqReady, rspValid, droppedCount, rspData, rspError);
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vecs++;
         if ({reqReady, rspValid, readOut} !== 3'b100) begin
            errs++; $display("FAIL abort_idle[%0d]: ready=%b v=%b rd=%b want 1 0 0", i, reqReady, rspValid, readOut);
         end
      end
   endtask

   initial begin
      test_reset;
      test_store;
      test_load;
      test_timeout;
      test_mismatch;
      test_saturate;
      test_abort;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
